// File: rtl/instr_fetch.sv
// Fetch stage of the RV32I core: PC register, single-outstanding imem read, valid/ready hand-off to decode.
// Optional misaligned-redirect trap enabled by defining IFETCH_MISALIGN_CHK_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic        instr_misalign
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_out_d;
    logic [31:0] redirect_target;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        misalign_d;
`endif

    // Low two bits of a redirect are dropped so pc_q stays word aligned.
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        valid_d   = instr_valid;
        instr_d   = instr;
        pc_out_d  = pc_out;
`ifdef IFETCH_MISALIGN_CHK_EN
        misalign_d = instr_misalign;
`endif
        imem_req  = (state_q == S_REQ);
        imem_addr = pc_q;

        case (state_q)
            S_REQ: begin
                if (redirect_valid) pc_d = redirect_target;
                if (imem_gnt) begin
                    state_d = S_WAIT;
                    kill_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        valid_d  = 1'b1;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A redirect with coincident instr_ready still counts as consumed.
                if (redirect_valid || instr_ready) begin
                    if (redirect_valid) pc_d = redirect_target;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = S_REQ;
`ifdef IFETCH_MISALIGN_CHK_EN
                    misalign_d = 1'b0;
`endif
                end
            end
            default: state_d = S_REQ;
        endcase

`ifdef IFETCH_MISALIGN_CHK_EN
        // Misaligned target is presented to decode as a flagged NOP; pc_q is left untouched.
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            pc_d       = pc_q;
            kill_d     = 1'b0;
            state_d    = S_HOLD;
            valid_d    = 1'b1;
            instr_d    = NOP_INSTR;
            pc_out_d   = redirect_pc;
            misalign_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            pc_out      <= RESET_PC;
`ifdef IFETCH_MISALIGN_CHK_EN
            instr_misalign <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            instr_valid <= valid_d;
            instr       <= instr_d;
            pc_out      <= pc_out_d;
`ifdef IFETCH_MISALIGN_CHK_EN
            instr_misalign <= misalign_d;
`endif
        end
    end

endmodule
